e_mdu_ctrl: RTL and testbench
=============================

# e_mdu_ctrl

Multi-cycle multiply/divide controller for the E stage of the five-stage MIPS pipeline. It accepts one MDU operation per idle cycle, owns the HI/LO register pair, and holds `busy` for a fixed latency so the stall unit can freeze younger MDU instructions. It also serves mfhi/mflo reads toward the M-stage register-write path.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd-class when enabled); legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–31.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `op_valid`  in  1  E-stage instruction is real (low for bubbles inserted on stall).
- `op`  in  4  MDU operation code (package encoding).
- `rs_data`  in  32  forwarded rs operand.
- `rt_data`  in  32  forwarded rt operand.
- `start`  out  1  combinational; a mult/div-class op is accepted this cycle.
- `busy`  out  1  registered; operation in flight.
- `hilo_out`  out  32  combinational; HI when op = MFHI, LO otherwise.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE, RUN. 5-bit down-counter `cnt`; 64-bit pending result `{p_hi,p_lo}`.
- IDLE, `op_valid`, op ∈ {MULT,MULTU,DIV,DIVU}: `start`=1. At the edge, the result is computed from `rs_data`/`rt_data` and latched into pending. `cnt` is loaded with the class latency minus 1, and the state moves to RUN.
- RUN: `busy`=1. `cnt` decrements each cycle. When `cnt`=0, pending is written to HI/LO at that edge and the state returns to IDLE.
- MULT: signed 32×32→64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero: runs the full latency; HI/LO are left unchanged at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE with `op_valid`: HI or LO takes `rs_data` at the next edge. No busy is raised.
- MFHI/MFLO: no state change. `hilo_out` reflects the current HI/LO, including a same-edge write completed by the previous cycle.
- Any MDU op with `op_valid` while `busy`=1: ignored, with no state change. The stall unit guarantees this never happens. The bench checks that the op is ignored.
- `op_valid`=0 or op=NONE: no effect.

## Timing
- Reset (async assert): state IDLE, `cnt`=0, `busy`=0, HI=LO=0, pending=0. Outputs are valid during reset. Reset asserted mid-RUN aborts the operation; pending is discarded.
- Accept at cycle t: `start`=1 in t; `busy`=1 in t+1 … t+N (N = class latency); HI/LO are new from t+N+1; `busy`=0 in t+N+1.
- Back-to-back: a new start is accepted in cycle t+N+1 and reads the fresh HI/LO.
- A stall condition for the stall unit is `start | busy` with an MDU op in D. This block only supplies the two signals.
- MTHI/MTLO accepted at t: visible on `hi`/`lo` at t+1.

## Configuration
- `MDU_MADD_EN` defined: adds MADD, MADDU, MSUB, MSUBU.
  - These use MULT_CYCLES latency.
  - The pending result is `{HI,LO} ± product` (signed or unsigned product), computed at accept from HI/LO as they stand at accept.
- Undefined: these codes are treated as NONE. No accumulate adder is synthesized.

## Structure
- Shared package `mdu_pkg`:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12
  - state enum {IDLE,RUN}
  - default latency constants
- Sub-module `mdu_core`: purely combinational 64-bit result generator. Inputs are op, operands, and current HI/LO. It contains the multiply, divide, divide-by-zero and accumulate logic. The controller instantiates one copy.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 at t → `busy` in t+1..t+5; from t+6, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- DIVU 100 / 7 → `busy` for 10 cycles, then LO=14, HI=2. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0x12345678, then DIV x / 0 → after 10 busy cycles HI is still 0x12345678. MFHI then drives `hilo_out`=0x12345678.
- MULTU issued at t+2 during a busy MULT → ignored; HI/LO get only the first result.
- `reset` low at t+3 of a DIV → `busy`=0 and HI=LO=0 immediately; after release, an MFLO returns 0.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → after 5 cycles HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged and `busy` stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// controller states, default latencies and op-class helpers (MDU_MADD_EN aware).
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    IDLE,
    RUN
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Without MDU_MADD_EN the accumulate codes fall out of the multiply class
  // and therefore behave exactly like OP_NONE.
  function automatic logic is_mul_class(mdu_op_e op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_class(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit {HI,LO} result generator: multiply, divide and, when
// MDU_MADD_EN is defined, multiply-accumulate/subtract against current HI/LO.
module mdu_core
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        wr_en
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
`ifdef MDU_MADD_EN
  logic [63:0] prod;
`endif

  always_comb begin
    smul = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    umul = {32'd0, rs_data} * {32'd0, rt_data};

    // One unsigned divider on magnitudes serves both DIV and DIVU; this also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow special-casing.
    a_neg = (op == OP_DIV) & rs_data[31];
    b_neg = (op == OP_DIV) & rt_data[31];
    a_mag = a_neg ? -rs_data : rs_data;
    b_mag = b_neg ? -rt_data : rt_data;
    if (b_mag == '0) b_mag = 32'd1;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    result = {hi, lo};
    wr_en  = 1'b0;
`ifdef MDU_MADD_EN
    prod   = '0;
`endif

    case (op)
      OP_MULT: begin
        result = smul;
        wr_en  = 1'b1;
      end
      OP_MULTU: begin
        result = umul;
        wr_en  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        result = {rem, quo};
        wr_en  = (rt_data != '0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        prod   = (op == OP_MADD || op == OP_MSUB) ? smul : umul;
        result = (op == OP_MSUB || op == OP_MSUBU) ? {hi, lo} - prod : {hi, lo} + prod;
        wr_en  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multi-cycle MDU controller owning HI/LO; holds busy for the class
// latency. Optional accumulate ops enabled by defining MDU_MADD_EN.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  mdu_op_e    op_e;
  mdu_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic        p_wr_q, p_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] core_result;
  logic        core_wr;

  assign op_e = mdu_op_e'(op);

  mdu_core u_core (
    .op      (op_e),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi_q),
    .lo      (lo_q),
    .result  (core_result),
    .wr_en   (core_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      p_wr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      p_wr_q  <= p_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    p_wr_d  = p_wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (is_mul_class(op_e) || is_div_class(op_e)) begin
            start   = 1'b1;
            p_d     = core_result;
            p_wr_d  = core_wr;
            cnt_d   = is_div_class(op_e) ? DIV_LOAD : MUL_LOAD;
            state_d = RUN;
          end else if (op_e == OP_MTHI) begin
            hi_d = rs_data;
          end else if (op_e == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        // A divide by zero still runs full latency but skips the write-back.
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (p_wr_q) {hi_d, lo_d} = p_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign hilo_out = (op_e == OP_MFHI) ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: directed corner cases plus random ops checked
// against an arithmetic reference model (honours MDU_MADD_EN).
module tb_e_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  e_mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .start    (start),
    .busy     (busy),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    int unsigned cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  function automatic bit is_long(logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  // Reference: returns 1 when HI/LO are to be overwritten with r.
  function automatic bit model(logic [3:0] o, logic [31:0] a, logic [31:0] b,
                               logic [31:0] h, logic [31:0] l, output logic [63:0] r);
    longint sa, sbv, q, rm;
    longint unsigned up;
    logic [63:0] tq, tr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    up  = 64'(a) * 64'(b);
    r   = {h, l};
    case (o)
      4'd1: r = sa * sbv;
      4'd2: r = up;
      4'd3: begin
        if (b == 0) return 1'b0;
        q  = sa / sbv;
        rm = sa % sbv;
        tq = q;
        tr = rm;
        r  = {tr[31:0], tq[31:0]};
      end
      4'd4: begin
        if (b == 0) return 1'b0;
        r = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      4'd9:  r = {h, l} + 64'(sa * sbv);
      4'd10: r = {h, l} + up;
      4'd11: r = {h, l} - 64'(sa * sbv);
      4'd12: r = {h, l} - up;
`endif
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Called and returns at posedge+1: presents one op for one cycle.
  task automatic drive(logic [3:0] o, logic [31:0] a, logic [31:0] b, bit in_busy);
    logic [63:0] r;
    bit          wr;
    bit          acc;
    exp_t        e;
    op_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    #1;
    acc = is_long(o) && !in_busy;
    check("start", start, acc);
    if (o == OP_MFHI) check("mfhi_out", hilo_out, m_hi);
    if (o == OP_MFLO) check("mflo_out", hilo_out, m_lo);
    wr = 1'b0;
    if (acc) begin
      wr       = model(o, a, b, m_hi, m_lo, r);
      e.cycles = (o == OP_DIV || o == OP_DIVU) ? DC : MC;
      e.hi     = wr ? r[63:32] : m_hi;
      e.lo     = wr ? r[31:0]  : m_lo;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = OP_NONE;
    if (acc && wr) {m_hi, m_lo} = r;
    if (!in_busy && o == OP_MTHI) begin
      m_hi = a;
      check("mthi_hi", hi, m_hi);
    end
    if (!in_busy && o == OP_MTLO) begin
      m_lo = a;
      check("mtlo_lo", lo, m_lo);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_idle: busy=%b after 64 cycles, required 0", busy);
    end
  endtask

  // Monitor: each falling edge of busy is a completed operation.
  int unsigned run_len   = 0;
  bit          prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) run_len++;
      else if (prev_busy) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL completion: unexpected op completed, hi=%h lo=%h", hi, lo);
        end else begin
          e = sbq.pop_front();
          check("busy_len", 64'(run_len), 64'(e.cycles));
          check("done_hi", hi, e.hi);
          check("done_lo", lo, e.lo);
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, required done");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ops [13];
    logic [3:0]  o;
    logic [31:0] a, b;

    ops = '{OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO,
            OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    reset    = 1'b0;
    op_valid = 1'b0;
    op       = OP_NONE;
    rs_data  = '0;
    rt_data  = '0;
    m_hi     = '0;
    m_lo     = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_start", start, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    drive(OP_MULT, 32'hFFFFFFFE, 32'h3, 1'b0);
    wait_idle();
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_idle();
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    drive(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    drive(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
    drive(OP_DIV, 32'd55, 32'd0, 1'b0);
    wait_idle();
    check("div0_hi", hi, 32'h12345678);
    drive(OP_MFHI, 32'h0, 32'h0, 1'b0);

    drive(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h0);

    // Op during busy at t+2 must be ignored.
    drive(OP_MULT, 32'd1234, 32'hFFFFFF00, 1'b0);
    @(posedge clk);
    #1;
    drive(OP_MULTU, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    wait_idle();

    // Back-to-back: second accept in the first idle cycle reads fresh HI/LO.
    drive(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    drive(OP_MFLO, 32'h0, 32'h0, 1'b0);

    // Reset at t+3 of a DIV.
    drive(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(OP_MFLO, 32'h0, 32'h0, 1'b0);

    drive(OP_MTHI, 32'h0, 32'h0, 1'b0);
    drive(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0);
    drive(OP_MADDU, 32'd1, 32'd1, 1'b0);
    wait_idle();
`ifdef MDU_MADD_EN
    check("maddu_hi", hi, 32'h1);
    check("maddu_lo", lo, 32'h0);
`else
    check("maddu_hi", hi, 32'h0);
    check("maddu_lo", lo, 32'hFFFFFFFF);
    check("maddu_busy", busy, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      o = ops[$urandom_range(0, 12)];
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      drive(o, a, b, 1'b0);
      if (is_long(o)) wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
